// File: rtl/winograd_pkg.sv
// Shared definitions for the winograd inner-product core and its accumulator stage.
package winograd_pkg;

  // Partial-sum width produced by the core for a given operand-B width.
  function automatic int psum_size(input int in_size_1);
    return ((in_size_1 + 1) * 2) + 6;
  endfunction

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} wacc_state_e;

endpackage

// File: rtl/winograd_acc_add.sv
// Tile-term adder: psum0 + psum1 - corr added to the accumulator, with overflow detect.
// WINOGRAD_ACC_SAT_EN selects saturation instead of two's-complement wrap on overflow.
module winograd_acc_add #(
  parameter int PSUM_SIZE = 24,
  parameter int ACC_SIZE  = 32
) (
  input  logic [ACC_SIZE-1:0]    acc_i,
  input  logic [2*PSUM_SIZE-1:0] psum_i,
  input  logic [PSUM_SIZE-1:0]   corr_i,
  output logic [ACC_SIZE-1:0]    sum_o,
  output logic                   ovf_o
);
  localparam int TW = PSUM_SIZE + 2;
  // Wide enough that neither operand is truncated, plus one guard bit.
  localparam int SW = ((ACC_SIZE > TW) ? ACC_SIZE : TW) + 1;

  logic [PSUM_SIZE-1:0] p0, p1;
  logic [TW-1:0]        term;
  logic [SW-1:0]        wide;
  logic [SW-ACC_SIZE:0] hi;

  assign p0 = psum_i[PSUM_SIZE-1:0];
  assign p1 = psum_i[2*PSUM_SIZE-1:PSUM_SIZE];

  always_comb begin
    term  = {{2{p0[PSUM_SIZE-1]}}, p0}
          + {{2{p1[PSUM_SIZE-1]}}, p1}
          - {{2{corr_i[PSUM_SIZE-1]}}, corr_i};
    wide  = {{(SW-TW){term[TW-1]}}, term}
          + {{(SW-ACC_SIZE){acc_i[ACC_SIZE-1]}}, acc_i};
    // Result fits ACC_SIZE only if every bit above the sign bit matches it.
    hi    = wide[SW-1:ACC_SIZE-1];
    ovf_o = !((&hi) || !(|hi));
`ifdef WINOGRAD_ACC_SAT_EN
    if (ovf_o)
      sum_o = wide[SW-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    else
      sum_o = wide[ACC_SIZE-1:0];
`else
    sum_o = wide[ACC_SIZE-1:0];
`endif
  end

endmodule

// File: rtl/winograd_acc.sv
// Accumulates exact per-tile dot-product terms over num_tiles tiles; valid/ready result.
// Optional WINOGRAD_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module winograd_acc
  import winograd_pkg::*;
#(
  parameter  int IN_SIZE_0 = 8,
  parameter  int IN_SIZE_1 = 8,
  parameter  int ACC_SIZE  = 32,
  parameter  int CNT_SIZE  = 8,
  localparam int PSUM_SIZE = psum_size(IN_SIZE_1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*PSUM_SIZE-1:0] psum_i,
  input  logic [PSUM_SIZE-1:0]   corr_i,
  input  logic [CNT_SIZE-1:0]    num_tiles_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [ACC_SIZE-1:0]    acc_o,
  output logic                   overflow_o
);

  if (IN_SIZE_0 < 1 || IN_SIZE_1 < 1) begin : g_bad_cfg
    $error("winograd_acc: operand widths must be positive");
  end

  wacc_state_e         state, state_nxt;
  logic [ACC_SIZE-1:0] acc, add_base, sum;
  logic [CNT_SIZE:0]   cnt, cnt_nxt, tiles, tiles_in, tiles_cur;
  logic                ovf, ovf_add, ovf_nxt;
  logic                accept, first, last;

  winograd_acc_add #(.PSUM_SIZE(PSUM_SIZE), .ACC_SIZE(ACC_SIZE)) u_add (
    .acc_i  (add_base),
    .psum_i (psum_i),
    .corr_i (corr_i),
    .sum_o  (sum),
    .ovf_o  (ovf_add)
  );

  // num_tiles_i == 0 encodes 2^CNT_SIZE: the extra MSB is set exactly then.
  assign tiles_in = {(num_tiles_i == '0), num_tiles_i};

  always_comb begin
    state_nxt = state;
    ready_o   = (state != HOLD);
    valid_o   = (state == HOLD);
    accept    = valid_i && ready_o;
    first     = (state == IDLE);
    add_base  = first ? '0 : acc;
    cnt_nxt   = first ? {{CNT_SIZE{1'b0}}, 1'b1} : cnt + 1'b1;
    tiles_cur = first ? tiles_in : tiles;
    ovf_nxt   = ovf_add | (!first && ovf);
    last      = (cnt_nxt == tiles_cur);
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = last ? HOLD : ACCUM;
      HOLD:        if (ready_i) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      tiles      <= '0;
      ovf        <= 1'b0;
      acc_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= sum;
        cnt   <= cnt_nxt;
        tiles <= tiles_cur;
        ovf   <= ovf_nxt;
        // Result registers only move on the closing beat, so they hold outside HOLD.
        if (last) begin
          acc_o      <= sum;
          overflow_o <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_acc.sv
// Scoreboard bench for winograd_acc: random beats vs. an arithmetic reference model.
module tb_winograd_acc;
  import winograd_pkg::*;

  localparam int PS = psum_size(8);
  localparam int AW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic valid_i, ready_o, valid_o, ready_i, overflow_o;
  logic [2*PS-1:0] psum;
  logic [PS-1:0]   corr;
  logic [CW-1:0]   nt;
  logic [AW-1:0]   acc_o;

  logic v16, rdy16, vo16, ri16, ovf16;
  logic [2*PS-1:0] psum16;
  logic [PS-1:0]   corr16;
  logic [CW-1:0]   nt16;
  logic [15:0]     acc16;

  always #5 clk = ~clk;

  winograd_acc #(.IN_SIZE_0(8), .IN_SIZE_1(8), .ACC_SIZE(AW), .CNT_SIZE(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .psum_i(psum),
    .corr_i(corr), .num_tiles_i(nt), .valid_o(valid_o), .ready_i(ready_i),
    .acc_o(acc_o), .overflow_o(overflow_o));

  winograd_acc #(.IN_SIZE_0(8), .IN_SIZE_1(8), .ACC_SIZE(16), .CNT_SIZE(CW)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(rdy16), .psum_i(psum16),
    .corr_i(corr16), .num_tiles_i(nt16), .valid_o(vo16), .ready_i(ri16),
    .acc_o(acc16), .overflow_o(ovf16));

  int checks = 0;
  int errors = 0;

  typedef struct { longint acc; bit ovf; } exp_t;
  exp_t sbq[$];

  bit     m_first = 1'b1;
  longint m_acc;
  bit     m_ovf;
  int     m_cnt, m_tiles;
  int     bp_mode = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic longint wrap(input longint s, input int w);
    longint m;
    m = s & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  // Reference: dot-product term per tile, summed exactly, then range-limited.
  function automatic void model_beat(input longint p0, input longint p1, input longint c,
                                     input int ntv);
    longint t, s, hi, lo;
    bit o;
    hi = (64'sd1 <<< (AW - 1)) - 1;
    lo = -(64'sd1 <<< (AW - 1));
    t  = p0 + p1 - c;
    if (m_first) begin
      m_tiles = (ntv == 0) ? (1 << CW) : ntv;
      m_cnt = 0;
      m_acc = 0;
      m_ovf = 1'b0;
    end
    s = m_acc + t;
    o = (s > hi) || (s < lo);
`ifdef WINOGRAD_ACC_SAT_EN
    if (o) s = (s > hi) ? hi : lo;
`else
    s = wrap(s, AW);
`endif
    m_acc = s;
    m_ovf = m_ovf | o;
    m_cnt++;
    m_first = 1'b0;
    if (m_cnt == m_tiles) begin
      sbq.push_back('{acc: m_acc, ovf: m_ovf});
      m_first = 1'b1;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat(input longint p0, input longint p1, input longint c, input int ntv);
    int guard;
    psum    = {PS'(p1), PS'(p0)};
    corr    = PS'(c);
    nt      = ntv[CW-1:0];
    valid_i = 1'b1;
    guard   = 0;
    @(negedge clk);
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    if (guard < 200) model_beat(p0, p1, c, ntv);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq.size() != 0 || valid_o) && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd_ps();
    logic [PS-1:0] r;
    r = PS'($urandom);
    return longint'($signed(r));
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ($urandom_range(0, 2) != 0);
      default: ready_i = 1'b0;
    endcase
  end

  // Monitor: pop on each result handshake, and require stability while held.
  bit            hold_prev = 1'b0;
  logic [AW-1:0] prev_acc;
  logic          prev_ovf;
  exp_t          e;
  always @(negedge clk) begin
    if (rst) hold_prev = 1'b0;
    else begin
      if (hold_prev) begin
        check("hold_acc_stable", longint'($signed(acc_o)), longint'($signed(prev_acc)));
        check("hold_ovf_stable", overflow_o, prev_ovf);
      end
      if (valid_o) begin
        check("ready_low_in_hold", ready_o, 0);
        if (ready_i) begin
          hold_prev = 1'b0;
          if (sbq.size() == 0) check("unexpected_result", 1, 0);
          else begin
            e = sbq.pop_front();
            check("acc", longint'($signed(acc_o)), e.acc);
            check("overflow", overflow_o, e.ovf);
          end
        end else begin
          hold_prev = 1'b1;
          prev_acc  = acc_o;
          prev_ovf  = overflow_o;
        end
      end else hold_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; psum = '0; corr = '0; nt = '0;
    v16 = 1'b0; ri16 = 1'b1; psum16 = '0; corr16 = '0; nt16 = '0;
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_acc", acc_o, 0);
    check("rst_ovf", overflow_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single tile, one-cycle latency.
    beat(10, -3, 4, 1);
    @(negedge clk);
    check("single_latency_valid", valid_o, 1);
    check("single_acc", longint'($signed(acc_o)), 3);
    drain();

    // Four tiles with bubbles; num_tiles_i changes mid-run.
    for (int i = 0; i < 4; i++) begin
      beat(100, 50, 20, (i < 2) ? 4 : 2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("four_tile_acc", longint'($signed(acc_o)), 520);
    drain();

    // Backpressure: result held, extra beat refused until consumed.
    bp_mode = 2;
    @(posedge clk); #1;
    beat(5, 6, 1, 1);
    fork
      beat(7, 0, 0, 1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", valid_o, 1);
          check("bp_ready", ready_o, 0);
          check("bp_acc", longint'($signed(acc_o)), 10);
        end
        bp_mode = 0;
      end
    join
    drain();

    // Corner term from all -128 operands.
    beat(131072, 131072, 131072, 1);
    drain();

    // num_tiles 0 = 256 tiles, large terms: overflows 32 bits.
    for (int i = 0; i < 256; i++) beat(8000000, 8000000, -8000000, 0);
    drain();

    // Randomized results with bubbles and random backpressure.
    bp_mode = 1;
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int b = 0; b < n; b++) begin
        beat(rnd_ps(), rnd_ps(), rnd_ps(), n);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    bp_mode = 0;
    drain();
    beat(900, 100, 1, 1);
    drain();

    // Reset mid-run discards the partial result.
    beat(1000, 0, 0, 4);
    beat(2000, 0, 0, 4);
    rst = 1'b1;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_ready", ready_o, 1);
    check("midrst_acc", acc_o, 0);
    check("midrst_ovf", overflow_o, 0);
    m_first = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_valid_after_rst", valid_o, 0);
    end
    @(posedge clk); #1;
    beat(7, 0, 0, 1);
    @(negedge clk);
    check("post_rst_acc", longint'($signed(acc_o)), 7);
    drain();

    // 16-bit accumulator: two tiles of 30000, then one tile that overflows alone.
    psum16 = {PS'(0), PS'(30000)}; corr16 = '0; nt16 = 8'd2; v16 = 1'b1;
    @(posedge clk); @(posedge clk); #1 v16 = 1'b0;
    @(negedge clk);
    check("acc16_valid", vo16, 1);
`ifdef WINOGRAD_ACC_SAT_EN
    check("acc16_two_tiles", longint'($signed(acc16)), 32767);
`else
    check("acc16_two_tiles", longint'($signed(acc16)), -5536);
`endif
    check("acc16_ovf", ovf16, 1);
    @(posedge clk); #1;
    psum16 = {PS'(0), PS'(40000)}; nt16 = 8'd1; v16 = 1'b1;
    @(negedge clk);
    check("acc16_ready", rdy16, 1);
    @(posedge clk); #1 v16 = 1'b0;
    @(negedge clk);
`ifdef WINOGRAD_ACC_SAT_EN
    check("acc16_first_beat", longint'($signed(acc16)), 32767);
`else
    check("acc16_first_beat", longint'($signed(acc16)), -25536);
`endif
    check("acc16_first_ovf", ovf16, 1);
    @(posedge clk); #1;

    check("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
